// File: rtl/d_ff_pet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_ff_pet_pkg
// Description : Shared defaults for the load-enable flop bank.
// Revision    : 1.0 - initial release
// ============================================================================
package d_ff_pet_pkg;

    localparam int c_max_width     = 64;
    localparam int c_default_width = 1;

    // Wide enough for any legal WIDTH; the top slices off what it needs.
    localparam logic [c_max_width-1:0] c_default_reset = '0;

endpackage : d_ff_pet_pkg
`default_nettype wire

// File: rtl/d_ff_pet_bit.sv
`default_nettype none
// ============================================================================
// Module      : d_ff_pet_bit
// Description : 1-bit rising-edge flop, synchronous active-high reset to
//               RESET_BIT, active-high load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module d_ff_pet_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic w_state_d;
    logic r_state_q;

    always_comb begin
        w_state_d = r_state_q;
        if (i_en) begin
            w_state_d = i_d;
        end
    end

    // Reset wins over the load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RESET_BIT;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign o_q = r_state_q;

endmodule : d_ff_pet_bit
`default_nettype wire

// File: rtl/d_ff_pet_syn_load_en.sv
`default_nettype none
// ============================================================================
// Module      : d_ff_pet_syn_load_en
// Description : WIDTH-bit register with synchronous active-high reset to
//               RESET_VALUE and load enable; one d_ff_pet_bit per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module d_ff_pet_syn_load_en
    import d_ff_pet_pkg::*;
#(
    parameter int               WIDTH       = c_default_width,
    parameter logic [WIDTH-1:0] RESET_VALUE = c_default_reset[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             en_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_pet_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .rst  (reset_in),
            .i_en (en_in),
            .i_d  (d_in[i]),
            .o_q  (q_out[i])
        );
    end

endmodule : d_ff_pet_syn_load_en
`default_nettype wire

// File: tb/tb_d_ff_pet_syn_load_en.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_ff_pet_syn_load_en
// Description : Scoreboard bench for a 1-bit (reset 0) and an 8-bit
//               (reset 8'hA5) instance driven with shared reset/enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_ff_pet_syn_load_en;

    typedef struct packed {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic       clk;
    logic       reset_in;
    logic       en_in;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total;
    int    bad;

    // Reference model state, advanced once per issued edge.
    logic       m1;
    logic [7:0] m8;

    d_ff_pet_syn_load_en u_dut1 (
        .clk      (clk),
        .reset_in (reset_in),
        .en_in    (en_in),
        .d_in     (d1),
        .q_out    (q1)
    );

    d_ff_pet_syn_load_en #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk      (clk),
        .reset_in (reset_in),
        .en_in    (en_in),
        .d_in     (d8),
        .q_out    (q8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one edge's inputs at the falling edge and queue the expected result.
    task automatic step(input logic r, input logic e, input logic [7:0] dv8,
                        input logic dv1, input string tag);
        @(negedge clk);
        reset_in = r;
        en_in    = e;
        d8       = dv8;
        d1       = dv1;
        if (r) begin
            m1 = 1'b0;
            m8 = 8'hA5;
        end else if (e) begin
            m1 = dv1;
            m8 = dv8;
        end
        sb_q.push_back('{q1: m1, q8: m8});
        tag_q.push_back(tag);
    endtask

    task automatic check_now(input string tag);
        total++;
        if (q1 !== m1 || q8 !== m8) begin
            bad++;
            $display("FAIL %s: q1=%b q8=%h expected q1=%b q8=%h", tag, q1, q8, m1, m8);
        end
    endtask

    // Monitor: one pop per rising edge that had stimulus queued for it.
    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (q1 !== e.q1 || q8 !== e.q8) begin
                bad++;
                $display("FAIL %s: q1=%b q8=%h expected q1=%b q8=%h", t, q1, q8, e.q1, e.q8);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        reset_in = 1'b0;
        en_in    = 1'b0;
        d1       = 1'b0;
        d8       = 8'h00;
        m1       = 1'b0;
        m8       = 8'h00;

        // Reset beats a simultaneous load.
        step(1'b1, 1'b1, 8'hFF, 1'b1, "reset_with_en");
        // Edge after reset release loads, then follows d one edge late.
        step(1'b0, 1'b1, 8'h3C, 1'b1, "load_1_3c");
        step(1'b0, 1'b1, 8'hC3, 1'b0, "load_0_c3");
        step(1'b0, 1'b1, 8'h3C, 1'b1, "load_1_3c_again");
        // Hold with d toggling every 8 ns across several periods.
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    step(1'b0, 1'b0, 8'hFF, 1'b0, "hold_toggle");
                end
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    #8;
                    d1 = ~d1;
                    d8 = ~d8;
                end
            end
        join
        // Reset pulse entirely between edges must not disturb q.
        step(1'b0, 1'b0, 8'h00, 1'b0, "pulse_setup");
        @(posedge clk);
        #2;
        reset_in = 1'b1;
        #4;
        reset_in = 1'b0;
        #1;
        check_now("reset_pulse_mid");
        step(1'b0, 1'b0, 8'h11, 1'b0, "reset_pulse_edge");
        // Reset mid-operation, then release with en/d set on the reset edge.
        step(1'b0, 1'b1, 8'h5A, 1'b1, "load_5a");
        step(1'b1, 1'b1, 8'h77, 1'b0, "reset_over_load");
        step(1'b0, 1'b0, 8'h77, 1'b0, "hold_after_reset");
        step(1'b0, 1'b1, 8'h81, 1'b1, "load_81");
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset_no_en");
        // Random traffic against the model (about 350 ns).
        for (int i = 0; i < 18; i++) begin
            step(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), 1'($urandom), "random");
        end
        // Let the monitor drain, bounded.
        for (int c = 0; c < 5 && sb_q.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: queue depth=%0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_d_ff_pet_syn_load_en
`default_nettype wire
